// File: rtl/vending_fsm_param.sv
// Parametrised vending controller: accumulates half-unit credit, vends at PRICE,
// and returns change or refunds as a train of one-cycle half-unit pulses.
module vending_fsm_param #(
  parameter int PRICE = 5,
  parameter int CNT_W = 4
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic             pi_money_half,
  input  logic             pi_money_one,
  input  logic             pi_cancel,
  output logic             po_cola,
  output logic             po_money,
  output logic             po_busy,
  output logic [CNT_W:0]   po_credit
);

  localparam logic [CNT_W:0] PRICE_V = (CNT_W+1)'(PRICE);

  // One-hot encoding leaves spare codes, so a corrupted state is detectable.
  typedef enum logic [1:0] {
    COLLECT  = 2'b01,
    DISPENSE = 2'b10
  } state_t;

  state_t           state_reg;
  logic [CNT_W:0]   credit_reg;
  logic [CNT_W:0]   chg_cnt_reg;

  logic [CNT_W:0]   coin;
  logic [CNT_W:0]   sum;
  logic [CNT_W:0]   change;

  // Credit stays below PRICE, so credit + 3 always fits in CNT_W+1 bits.
  always_comb begin
    coin   = (CNT_W+1)'(pi_money_half) + ((CNT_W+1)'(pi_money_one) << 1);
    sum    = credit_reg + coin;
    change = sum - PRICE_V;
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_reg   <= COLLECT;
      credit_reg  <= '0;
      chg_cnt_reg <= '0;
      po_cola     <= 1'b0;
      po_money    <= 1'b0;
      po_busy     <= 1'b0;
    end else begin
      po_cola <= 1'b0;
      case (state_reg)
        COLLECT: begin
          po_money <= 1'b0;
          po_busy  <= 1'b0;
          if (pi_cancel) begin
            if (sum != '0) begin
              chg_cnt_reg <= sum;
              credit_reg  <= '0;
              state_reg   <= DISPENSE;
              po_money    <= 1'b1;
              po_busy     <= 1'b1;
            end
          end else if (sum >= PRICE_V) begin
            po_cola    <= 1'b1;
            credit_reg <= '0;
            if (change != '0) begin
              chg_cnt_reg <= change;
              state_reg   <= DISPENSE;
              po_money    <= 1'b1;
              po_busy     <= 1'b1;
            end
          end else begin
            credit_reg <= sum;
          end
        end

        DISPENSE: begin
          credit_reg <= '0;
          // Coin and cancel strobes are deliberately dropped here.
          if (chg_cnt_reg <= (CNT_W+1)'(1)) begin
            chg_cnt_reg <= '0;
            state_reg   <= COLLECT;
            po_money    <= 1'b0;
            po_busy     <= 1'b0;
          end else begin
            chg_cnt_reg <= chg_cnt_reg - (CNT_W+1)'(1);
            po_money    <= 1'b1;
            po_busy     <= 1'b1;
          end
        end

        default: begin
          state_reg   <= COLLECT;
          credit_reg  <= '0;
          chg_cnt_reg <= '0;
          po_money    <= 1'b0;
          po_busy     <= 1'b0;
        end
      endcase
    end
  end

  assign po_credit = credit_reg;

endmodule
